// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Round-robin two-requester front end for a single-port byte-lane RAM,
//          with load extraction/extension. Optional MEM_PORT_ALIGN_CHK_EN
//          enables misalignment / reserved-width error reporting.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W        = 12,
    parameter bit RR_RESET_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_width,
    input  logic              m0_sext,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_width,
    input  logic              m1_sext,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    logic [0:0] r_state;
    logic       r_last;
    logic       r_id;
    logic [1:0] r_width;
    logic       r_sext;
    logic [1:0] r_off;
    logic       r_err;
    logic       r_we;

    logic        w_idle, w_resp, w_grant, w_win;
    logic        w_we, w_sext, w_err;
    logic [1:0]  w_width;
    logic [31:0] w_addr, w_wdata;
    logic [3:0]  w_lanes;
    logic [31:0] w_lane_data;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_ext, w_rdata;
    logic        w_unused;

    // Outputs are gated with reset so they collapse asynchronously.
    assign w_idle  = (r_state == S_IDLE) & reset;
    assign w_resp  = (r_state == S_RESP) & reset;
    assign w_grant = w_idle & (m0_req | m1_req);
    assign w_win   = (m0_req & m1_req) ? ~r_last : m1_req;

    assign w_we    = w_win ? m1_we    : m0_we;
    assign w_width = w_win ? m1_width : m0_width;
    assign w_sext  = w_win ? m1_sext  : m0_sext;
    assign w_addr  = w_win ? m1_addr  : m0_addr;
    assign w_wdata = w_win ? m1_wdata : m0_wdata;

`ifdef MEM_PORT_ALIGN_CHK_EN
    always_comb begin
        case (w_width)
            2'b00:   w_err = |w_addr[1:0];
            2'b01:   w_err = w_addr[0];
            2'b10:   w_err = 1'b0;
            default: w_err = 1'b1;
        endcase
    end
`else
    assign w_err = 1'b0;
`endif

    // Width 11 falls through to the word lane pattern.
    always_comb begin
        w_lanes     = 4'b1111;
        w_lane_data = w_wdata;
        case (w_width)
            2'b01: begin
                if (w_addr[1]) begin
                    w_lanes     = 4'b1100;
                    w_lane_data = {w_wdata[15:0], 16'h0000};
                end else begin
                    w_lanes     = 4'b0011;
                    w_lane_data = {16'h0000, w_wdata[15:0]};
                end
            end
            2'b10: begin
                w_lanes     = 4'b0001 << w_addr[1:0];
                w_lane_data = {4{w_wdata[7:0]}} &
                              {{8{w_lanes[3]}}, {8{w_lanes[2]}},
                               {8{w_lanes[1]}}, {8{w_lanes[0]}}};
            end
            default: ;
        endcase
    end

    assign ram_en    = w_grant & ~w_err;
    assign ram_we    = (ram_en & w_we) ? w_lanes : 4'b0000;
    assign ram_addr  = w_grant ? w_addr[ADDR_W+1:2] : '0;
    assign ram_wdata = (w_grant & w_we) ? w_lane_data : 32'h0;

    assign m0_gnt = w_grant & ~w_win;
    assign m1_gnt = w_grant &  w_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_last  <= ~RR_RESET_PRIO;
            r_id    <= 1'b0;
            r_width <= 2'b00;
            r_sext  <= 1'b0;
            r_off   <= 2'b00;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_RESP;
                        r_last  <= w_win;
                        r_id    <= w_win;
                        r_width <= w_width;
                        r_sext  <= w_sext;
                        r_off   <= w_addr[1:0];
                        r_err   <= w_err;
                        r_we    <= w_we;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_half = r_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        case (r_off)
            2'b00:   w_byte = ram_rdata[7:0];
            2'b01:   w_byte = ram_rdata[15:8];
            2'b10:   w_byte = ram_rdata[23:16];
            default: w_byte = ram_rdata[31:24];
        endcase
    end

    always_comb begin
        case (r_width)
            2'b01:   w_ext = {{16{r_sext & w_half[15]}}, w_half};
            2'b10:   w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
            default: w_ext = ram_rdata;
        endcase
    end

    // Stores and errored accesses complete with zero data.
    assign w_rdata = (w_resp & ~r_err & ~r_we) ? w_ext : 32'h0;

    assign m0_rvalid = w_resp & ~r_id;
    assign m1_rvalid = w_resp &  r_id;
    assign m0_rdata  = m0_rvalid ? w_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? w_rdata : 32'h0;
    assign m0_err    = m0_rvalid & r_err;
    assign m1_err    = m1_rvalid & r_err;

    assign w_unused = &{1'b0, w_addr[31:ADDR_W+2]};

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed, table-driven bench for mem_port_arbiter with a RAM model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m0_sext = 0;
    logic [1:0]  m0_width = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 0, m1_we = 0, m1_sext = 0;
    logic [1:0]  m1_width = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(12), .RR_RESET_PRIO(1'b0)) dut (
        .clk(clk), .reset(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_width(m0_width), .m0_sext(m0_sext),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_width(m1_width), .m1_sext(m1_sext),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM, 16 words, 1-cycle read latency.
    logic [31:0] mem [0:15] = '{0: 32'h8001_1234, 2: 32'h00FF_7F80, default: 32'h0};

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= mem[ram_addr[3:0]];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (ram_we[i]) mem[ram_addr[3:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
    end

    typedef struct packed {
        logic        mst;
        logic        we;
        logic [1:0]  width;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mst, input logic we, input logic [1:0] width,
                         input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
        m0_we = we; m0_width = width; m0_sext = sext; m0_addr = addr; m0_wdata = wdata;
        m1_we = we; m1_width = width; m1_sext = sext; m1_addr = addr; m1_wdata = wdata;
        m0_req = ~mst;
        m1_req = mst;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_gnt"},    {30'b0, m1_gnt, m0_gnt}, 32'h0);
        chk({name, "_rvalid"}, {30'b0, m1_rvalid, m0_rvalid}, 32'h0);
        chk({name, "_ram_en"}, {31'b0, ram_en}, 32'h0);
        chk({name, "_ram_we"}, {28'b0, ram_we}, 32'h0);
        chk({name, "_rdata"},  m0_rdata | m1_rdata, 32'h0);
    endtask

    initial begin
        //             mst we  w     sx addr          wdata          exp_we  exp_wdata      raddr  exp_rdata
        vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h0000_00A5, 4'b0100, 32'h00A5_0000, 32'd1, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h0,         32'd1, 32'h00A5_0000};
        vecs[2]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,         4'b0000, 32'h0,         32'd0, 32'hFFFF_8001};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,         4'b0000, 32'h0,         32'd0, 32'h0000_8001};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h1234_BEEF, 4'b1100, 32'hBEEF_0000, 32'd2, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0008, 32'h0,         4'b0000, 32'h0,         32'd2, 32'hFFFF_FF80};
        vecs[6]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0009, 32'h0,         4'b0000, 32'h0,         32'd2, 32'h0000_007F};
        vecs[7]  = '{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0,         4'b0000, 32'h0,         32'd2, 32'h0000_BEEF};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_000C, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'd3, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0,         4'b0000, 32'h0,         32'd3, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_000C, 32'hFFFF_5555, 4'b0011, 32'h0000_5555, 32'd3, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_000F, 32'h0000_0011, 4'b1000, 32'h1100_0000, 32'd3, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0,         4'b0000, 32'h0,         32'd3, 32'h11AD_5555};

        // Reset, then idle with no requests.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet("in_reset");
        end
        rst_n = 1'b1;
        tick();
        chk_quiet("idle");
        tick();

        // Single-requester accesses.
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].mst, vecs[v].we, vecs[v].width, vecs[v].sext, vecs[v].addr, vecs[v].wdata);
            #1;
            chk($sformatf("v%0d_gnt", v), {30'b0, m1_gnt, m0_gnt}, vecs[v].mst ? 32'h2 : 32'h1);
            chk($sformatf("v%0d_ram_en", v), {31'b0, ram_en}, 32'h1);
            chk($sformatf("v%0d_ram_we", v), {28'b0, ram_we}, {28'b0, vecs[v].exp_we});
            chk($sformatf("v%0d_ram_addr", v), {20'b0, ram_addr}, vecs[v].exp_raddr);
            if (vecs[v].we)
                chk($sformatf("v%0d_ram_wdata", v), ram_wdata, vecs[v].exp_wdata);
            tick();
            m0_req = 1'b0;
            m1_req = 1'b0;
            #1;
            chk($sformatf("v%0d_rvalid", v), {30'b0, m1_rvalid, m0_rvalid}, vecs[v].mst ? 32'h2 : 32'h1);
            chk($sformatf("v%0d_no_gnt_resp", v), {30'b0, m1_gnt, m0_gnt}, 32'h0);
            chk($sformatf("v%0d_rdata", v), vecs[v].mst ? m1_rdata : m0_rdata, vecs[v].exp_rdata);
            chk($sformatf("v%0d_err", v), {31'b0, m0_err | m1_err}, 32'h0);
            tick();
        end

        // Misaligned word load at 0x3.
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0);
        #1;
        chk("mis_gnt", {31'b0, m0_gnt}, 32'h1);
`ifdef MEM_PORT_ALIGN_CHK_EN
        chk("mis_ram_en", {31'b0, ram_en}, 32'h0);
        chk("mis_ram_we", {28'b0, ram_we}, 32'h0);
`else
        chk("mis_ram_en", {31'b0, ram_en}, 32'h1);
        chk("mis_ram_addr", {20'b0, ram_addr}, 32'h0);
`endif
        tick();
        m0_req = 1'b0;
        #1;
        chk("mis_rvalid", {31'b0, m0_rvalid}, 32'h1);
`ifdef MEM_PORT_ALIGN_CHK_EN
        chk("mis_err", {31'b0, m0_err}, 32'h1);
        chk("mis_rdata", m0_rdata, 32'h0);
`else
        chk("mis_err", {31'b0, m0_err}, 32'h0);
        chk("mis_rdata", m0_rdata, 32'h8001_1234);
`endif
        tick();

        // Contention from reset: m0, -, m1, -, m0, -, m1, -.
        rst_n = 1'b0;
        tick();
        tick();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        m1_req = 1'b1;
        rst_n  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr%0d_m0_gnt", c), {31'b0, m0_gnt}, {31'b0, (c % 4) == 0});
            chk($sformatf("rr%0d_m1_gnt", c), {31'b0, m1_gnt}, {31'b0, (c % 4) == 2});
            chk($sformatf("rr%0d_m0_rvalid", c), {31'b0, m0_rvalid}, {31'b0, (c % 4) == 1});
            tick();
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();

        // Reset in the RESP cycle of an m0 load; pointer must return to reset value.
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_mid_gnt", {31'b0, m0_gnt}, 32'h1);
        tick();
        m0_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_mid_rvalid_async", {31'b0, m0_rvalid}, 32'h0);
        tick();
        chk("rst_mid_rvalid_held", {31'b0, m0_rvalid}, 32'h0);
        rst_n  = 1'b1;
        m0_req = 1'b1;
        m1_req = 1'b1;
        #1;
        chk("rst_ptr_m0_gnt", {31'b0, m0_gnt}, 32'h1);
        chk("rst_ptr_m1_gnt", {31'b0, m1_gnt}, 32'h0);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        #1;
        chk("rst_post_rvalid", {31'b0, m0_rvalid}, 32'h1);
        tick();

        // m1 alone right after a reset release.
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        m0_req = 1'b0;
        #1;
        chk("m0_resp_start", {31'b0, m0_gnt}, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        m1_req = 1'b1;
        #1;
        chk("m1_first_gnt", {31'b0, m1_gnt}, 32'h1);
        tick();
        m1_req = 1'b0;
        #1;
        chk("m1_first_rvalid", {31'b0, m1_rvalid}, 32'h1);
        chk("m1_first_rdata", m1_rdata, 32'h8001_1234);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
